// File: rtl/readout_feature_quantizer.sv
// readout_feature_quantizer
//   Integrates signed I/Q samples over a readout window split into NUM_SEG
//   segments of SEG_LEN samples each. Each segment sum is reduced to a
//   FEAT_BITS-wide unsigned code per channel, and the packed code vector is
//   presented on a valid/ready output register.
//
// Ports
//   clk, rst_n            : clock, synchronous active-low reset
//   in_valid/in_ready     : input sample handshake
//   in_i, in_q            : signed I/Q samples
//   in_last               : marks the final sample of a frame
//   out_valid/out_ready   : feature vector handshake
//   features              : packed codes, segment s I at slot 2s, Q at 2s+1
//   frame_err             : one-cycle pulse on a framing violation
module readout_feature_quantizer #(
    parameter int SAMPLE_W  = 16,
    parameter int NUM_SEG   = 8,
    parameter int SEG_LEN   = 32,
    parameter int FEAT_BITS = 2,
    parameter int SHIFT     = 4,
    localparam int LOG2_SEG = $clog2(SEG_LEN),
    localparam int OUT_W    = 2 * NUM_SEG * FEAT_BITS,
    localparam int ACC_W    = SAMPLE_W + LOG2_SEG
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [SAMPLE_W-1:0] in_i,
    input  logic signed [SAMPLE_W-1:0] in_q,
    input  logic                       in_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OUT_W-1:0]           features,
    output logic                       frame_err
);

    localparam int IDX_W = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1;
    localparam int QSH   = LOG2_SEG + SHIFT;
    localparam int HALF  = 2 ** (FEAT_BITS - 1);
    localparam int MAXC  = (2 ** FEAT_BITS) - 1;

    typedef enum logic [0:0] {
        ST_ACC,
        ST_DRAIN
    } state_t;

    state_t                    r_state;
    state_t                    w_state_next;
    logic [LOG2_SEG-1:0]       r_seg_cnt;
    logic [IDX_W-1:0]          r_seg_idx;
    logic signed [ACC_W-1:0]   r_acc_i;
    logic signed [ACC_W-1:0]   r_acc_q;
    logic [OUT_W-1:0]          r_stage;
    logic [OUT_W-1:0]          r_features;
    logic                      r_out_valid;
    logic                      r_frame_err;

    logic                      w_hs;
    logic                      w_seg_last;
    logic                      w_frame_pos;
    logic signed [ACC_W-1:0]   w_ext_i;
    logic signed [ACC_W-1:0]   w_ext_q;
    logic signed [ACC_W-1:0]   w_sum_i;
    logic signed [ACC_W-1:0]   w_sum_q;
    logic [FEAT_BITS-1:0]      w_code_i;
    logic [FEAT_BITS-1:0]      w_code_q;
    logic [OUT_W-1:0]          w_stage_next;

    // Mean-and-shift collapses into one arithmetic shift of the segment sum;
    // the shift floors toward minus infinity, then the code is re-centred.
    function automatic logic [FEAT_BITS-1:0] quantize(input logic signed [ACC_W-1:0] sum);
        logic signed [ACC_W-1:0] sh;
        logic signed [ACC_W:0]   v;
        sh = sum >>> QSH;
        v  = {sh[ACC_W-1], sh} + (ACC_W+1)'(HALF);
        if (v[ACC_W]) begin
            return '0;
        end else if (v > (ACC_W+1)'(MAXC)) begin
            return '1;
        end else begin
            return v[FEAT_BITS-1:0];
        end
    endfunction

    assign out_valid = r_out_valid;
    assign features  = r_features;
    assign frame_err = r_frame_err;

    assign w_seg_last  = (r_seg_cnt == LOG2_SEG'(SEG_LEN - 1));
    assign w_frame_pos = w_seg_last && (r_seg_idx == IDX_W'(NUM_SEG - 1));

    assign w_ext_i  = ACC_W'(in_i);
    assign w_ext_q  = ACC_W'(in_q);
    assign w_sum_i  = r_acc_i + w_ext_i;
    assign w_sum_q  = r_acc_q + w_ext_q;
    assign w_code_i = quantize(w_sum_i);
    assign w_code_q = quantize(w_sum_q);

    // Only the frame-final sample is held back while the previous vector is
    // unconsumed; counters sit at zero in DRAIN so that state never stalls.
    always_comb begin
        w_state_next = r_state;
        in_ready     = rst_n && ((r_state == ST_DRAIN) || !(r_out_valid && w_frame_pos));
        w_hs         = in_valid && in_ready;
        case (r_state)
            ST_ACC: begin
                if (w_hs && w_frame_pos && !in_last) begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_hs && in_last) begin
                    w_state_next = ST_ACC;
                end
            end
            default: w_state_next = ST_ACC;
        endcase
    end

    always_comb begin
        w_stage_next = r_stage;
        for (int unsigned s = 0; s < NUM_SEG; s++) begin
            if (32'(r_seg_idx) == s) begin
                w_stage_next[(2*s)*FEAT_BITS +: FEAT_BITS]   = w_code_i;
                w_stage_next[(2*s+1)*FEAT_BITS +: FEAT_BITS] = w_code_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_ACC;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_seg_cnt   <= '0;
            r_seg_idx   <= '0;
            r_acc_i     <= '0;
            r_acc_q     <= '0;
            r_stage     <= '0;
            r_features  <= '0;
            r_out_valid <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_hs && (r_state == ST_ACC)) begin
                if (in_last && !w_frame_pos) begin
                    // Early end: abandon the partial frame. Staging slots are
                    // all rewritten by the next frame before being published.
                    r_frame_err <= 1'b1;
                    r_seg_cnt   <= '0;
                    r_seg_idx   <= '0;
                end else begin
                    r_acc_i <= (r_seg_cnt == '0) ? w_ext_i : w_sum_i;
                    r_acc_q <= (r_seg_cnt == '0) ? w_ext_q : w_sum_q;
                    if (w_seg_last) begin
                        r_stage   <= w_stage_next;
                        r_seg_cnt <= '0;
                        if (w_frame_pos) begin
                            r_features  <= w_stage_next;
                            r_out_valid <= 1'b1;
                            r_seg_idx   <= '0;
                            if (!in_last) begin
                                r_frame_err <= 1'b1;
                            end
                        end else begin
                            r_seg_idx <= r_seg_idx + 1'b1;
                        end
                    end else begin
                        r_seg_cnt <= r_seg_cnt + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_readout_feature_quantizer.sv
// Bench for readout_feature_quantizer: directed frames, a frame-level
// reference model compared every cycle, plus hand-computed literal checks.
module tb_readout_feature_quantizer;

    localparam int SW    = 8;
    localparam int NS    = 2;
    localparam int SL    = 4;
    localparam int FB    = 2;
    localparam int SH    = 4;
    localparam int TOTAL = NS * SL;
    localparam int DIV   = 64;            // SEG_LEN * 2**SHIFT
    localparam int OW    = 2 * NS * FB;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [SW-1:0] in_i;
    logic signed [SW-1:0] in_q;
    logic                 in_last;
    logic                 out_valid;
    logic                 out_ready;
    logic [OW-1:0]        features;
    logic                 frame_err;

    int total = 0;
    int bad   = 0;
    bit cmp_en = 1'b0;

    readout_feature_quantizer #(
        .SAMPLE_W (SW),
        .NUM_SEG  (NS),
        .SEG_LEN  (SL),
        .FEAT_BITS(FB),
        .SHIFT    (SH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_i     (in_i),
        .in_q     (in_q),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .features (features),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (frame level) ----------------
    int        m_si[$];
    int        m_sq[$];
    bit        m_drain;
    bit        m_ov;
    bit [OW-1:0] m_feat;
    bit        m_err;

    function automatic int floordiv(input int a, input int d);
        if (a >= 0) return a / d;
        return -((-a + d - 1) / d);
    endfunction

    function automatic int code_of(input int sum);
        int c;
        c = floordiv(sum, DIV) + 2 ** (FB - 1);
        if (c < 0) c = 0;
        if (c > 2 ** FB - 1) c = 2 ** FB - 1;
        return c;
    endfunction

    function automatic bit model_ready();
        return rst_n && (m_drain || !(m_ov && (m_si.size() == TOTAL - 1)));
    endfunction

    always @(posedge clk) begin
        bit hs;
        bit [OW-1:0] f;
        hs = in_valid && model_ready();
        if (!rst_n) begin
            m_si.delete();
            m_sq.delete();
            m_drain = 1'b0;
            m_ov    = 1'b0;
            m_feat  = '0;
            m_err   = 1'b0;
        end else begin
            m_err = 1'b0;
            if (m_ov && out_ready) m_ov = 1'b0;
            if (hs) begin
                if (m_drain) begin
                    if (in_last) m_drain = 1'b0;
                end else begin
                    m_si.push_back(int'(in_i));
                    m_sq.push_back(int'(in_q));
                    if (m_si.size() == TOTAL) begin
                        f = '0;
                        for (int s = 0; s < NS; s++) begin
                            int si, sq;
                            si = 0;
                            sq = 0;
                            for (int k = 0; k < SL; k++) begin
                                si += m_si[s*SL + k];
                                sq += m_sq[s*SL + k];
                            end
                            f[(2*s)*FB +: FB]   = FB'(code_of(si));
                            f[(2*s+1)*FB +: FB] = FB'(code_of(sq));
                        end
                        m_feat = f;
                        m_ov   = 1'b1;
                        m_si.delete();
                        m_sq.delete();
                        if (!in_last) begin
                            m_err   = 1'b1;
                            m_drain = 1'b1;
                        end
                    end else if (in_last) begin
                        m_err = 1'b1;
                        m_si.delete();
                        m_sq.delete();
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("in_ready", 32'(in_ready), 32'(model_ready()));
            chk("out_valid", 32'(out_valid), 32'(m_ov));
            chk("features", 32'(features), 32'(m_feat));
            chk("frame_err", 32'(frame_err), 32'(m_err));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int si, input int sq, input logic last, output int waits);
        bit r;
        in_valid = 1'b1;
        in_i     = SW'(si);
        in_q     = SW'(sq);
        in_last  = last;
        waits    = 0;
        forever begin
            @(negedge clk);
            r = in_ready;
            @(posedge clk);
            #1;
            if (r) break;
            waits++;
            if (waits > 50) begin
                total++;
                bad++;
                $display("FAIL send_timeout: got no handshake within %0d cycles", waits);
                break;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic frame(input int i0, input int q0, input int i1, input int q1, input logic lastf);
        int w;
        for (int k = 0; k < TOTAL; k++) begin
            send((k < SL) ? i0 : i1, (k < SL) ? q0 : q1, (k == TOTAL - 1) ? lastf : 1'b0, w);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_i      = '0;
        in_q      = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_features", 32'(features), 0);
        chk("rst_frame_err", 32'(frame_err), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        cmp_en = 1'b1;
        rst_n  = 1'b1;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 1);
        tick();

        // Quantization
        frame(16, -16, 0, 100, 1'b1);
        chk("q1_valid", 32'(out_valid), 1);
        chk("q1_features", 32'(features), 32'h0E7);
        tick();
        chk("q1_consumed", 32'(out_valid), 0);
        frame(-128, -16, -128, 100, 1'b1);
        chk("q2_features", 32'(features), 32'h0C4);
        tick();

        // Backpressure
        out_ready = 1'b0;
        frame(16, -16, 0, 100, 1'b1);
        chk("bp_f1_features", 32'(features), 32'h0E7);
        for (int k = 0; k < TOTAL - 1; k++) begin
            send(-128, (k < SL) ? -16 : 100, 1'b0, w);
            chk("bp_accept_wait", 32'(w), 0);
        end
        in_valid = 1'b1;
        in_i     = -8'sd128;
        in_q     = 8'sd100;
        in_last  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("bp_stall_ready", 32'(in_ready), 0);
            chk("bp_hold_features", 32'(features), 32'h0E7);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_drop_valid", 32'(out_valid), 0);
        chk("bp_ready_after_drop", 32'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("bp_f2_valid", 32'(out_valid), 1);
        chk("bp_f2_features", 32'(features), 32'h0C4);
        out_ready = 1'b1;
        tick();
        chk("bp_f2_consumed", 32'(out_valid), 0);

        // Early last
        for (int k = 0; k < 5; k++) begin
            send((k < SL) ? 16 : 0, (k < SL) ? -16 : 100, (k == 4) ? 1'b1 : 1'b0, w);
        end
        chk("early_err", 32'(frame_err), 1);
        chk("early_no_valid", 32'(out_valid), 0);
        tick();
        chk("early_err_clear", 32'(frame_err), 0);
        frame(16, -16, 0, 100, 1'b1);
        chk("early_next_features", 32'(features), 32'h0E7);
        tick();

        // Missing last
        frame(-16, 16, 100, 0, 1'b0);
        chk("miss_valid", 32'(out_valid), 1);
        chk("miss_features", 32'(features), 32'h0BD);
        chk("miss_err", 32'(frame_err), 1);
        send(5, 7, 1'b0, w);
        send(-3, 9, 1'b0, w);
        send(1, 1, 1'b1, w);
        tick();
        tick();
        chk("drain_no_valid", 32'(out_valid), 0);
        chk("drain_no_err", 32'(frame_err), 0);
        frame(32, -65, 32, -65, 1'b1);
        chk("post_drain_features", 32'(features), 32'h033);
        tick();

        // Mid-frame reset
        for (int k = 0; k < 3; k++) send(100, 100, 1'b0, w);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mr_no_valid", 32'(out_valid), 0);
        chk("mr_no_err", 32'(frame_err), 0);
        chk("mr_features_clear", 32'(features), 0);
        tick();
        frame(-33, 63, -32, -1, 1'b1);
        chk("mr_valid", 32'(out_valid), 1);
        chk("mr_features", 32'(features), 32'h04C);
        tick();
        tick();

        cmp_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
